// File: rtl/hit_detector.sv
// rtl/hit_detector.sv - whack-a-mole hit detector: per-hole arm/prime FSMs, strike lockout, hit counter.
// Optional miss strobe generation enabled by defining HIT_DETECTOR_MISS_EN.
module hit_detector #(
  parameter int NUM_HOLES      = 5,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 hammer_pulse,
  input  logic [NUM_HOLES-1:0] swith,
  input  logic [NUM_HOLES-1:0] mole_led,
  output logic [NUM_HOLES-1:0] hit_vec,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [CNT_W-1:0]     hit_count,
  output logic                 lockout
);

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_PRIMED} state_t;

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  state_t               r_state     [NUM_HOLES];
  state_t               w_state_nxt [NUM_HOLES];
  logic [NUM_HOLES-1:0] r_swith_q;
  logic [NUM_HOLES-1:0] r_mole_q;
  logic [NUM_HOLES-1:0] r_arm_snap;
  logic [NUM_HOLES-1:0] w_arm_snap_nxt;
  logic [NUM_HOLES-1:0] w_primed;
  logic [NUM_HOLES-1:0] r_hit_vec;
  logic [LW-1:0]        r_lock_cnt;
  logic                 w_lockout;
  logic                 w_strike;
  logic [4:0]           w_pop;
  logic [CNT_W+4:0]     w_sum;
  logic [CNT_W-1:0]     r_hit_count;
  logic [CNT_W-1:0]     w_count_nxt;

  assign w_lockout = (r_lock_cnt != '0);
  assign w_strike  = hammer_pulse & enable & ~w_lockout;

  always_comb begin
    w_primed = '0;
    w_pop    = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      w_primed[i] = (r_state[i] == S_PRIMED);
      w_pop       = w_pop + 5'(w_primed[i]);
    end
  end

  // Only holes primed before the strike cycle score; the strike re-arms every lit hole
  // from the current switch level, so same-cycle switch edges never count.
  always_comb begin
    w_arm_snap_nxt = r_arm_snap;
    for (int i = 0; i < NUM_HOLES; i++) begin
      w_state_nxt[i] = r_state[i];
      if (!enable || !mole_led[i]) begin
        w_state_nxt[i] = S_OFF;
      end else if (w_strike) begin
        w_state_nxt[i]    = S_ARMED;
        w_arm_snap_nxt[i] = swith[i];
      end else begin
        case (r_state[i])
          S_OFF: begin
            if (!r_mole_q[i]) begin
              w_state_nxt[i]    = S_ARMED;
              w_arm_snap_nxt[i] = swith[i];
            end
          end
          S_ARMED: begin
            if (mode ? (swith[i] != r_arm_snap[i]) : (swith[i] != r_swith_q[i]))
              w_state_nxt[i] = S_PRIMED;
          end
          S_PRIMED: begin
            if (mode && (swith[i] == r_arm_snap[i]))
              w_state_nxt[i] = S_ARMED;
          end
          default: w_state_nxt[i] = S_OFF;
        endcase
      end
    end
  end

  always_comb begin
    w_sum = {5'b0, r_hit_count} + {{CNT_W{1'b0}}, (w_strike ? w_pop : 5'd0)};
    if (|w_sum[CNT_W+4:CNT_W])
      w_count_nxt = {CNT_W{1'b1}};
    else
      w_count_nxt = w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_swith_q   <= '0;
      r_mole_q    <= '0;
      r_arm_snap  <= '0;
      r_hit_vec   <= '0;
      r_lock_cnt  <= '0;
      r_hit_count <= '0;
      for (int i = 0; i < NUM_HOLES; i++) r_state[i] <= S_OFF;
    end else begin
      r_swith_q   <= swith;
      r_mole_q    <= mole_led;
      r_arm_snap  <= w_arm_snap_nxt;
      r_state     <= w_state_nxt;
      r_hit_vec   <= w_strike ? w_primed : '0;
      r_hit_count <= w_count_nxt;
      if (!enable)
        r_lock_cnt <= '0;
      else if (w_strike)
        r_lock_cnt <= LW'(LOCKOUT_CYCLES);
      else if (w_lockout)
        r_lock_cnt <= r_lock_cnt - LW'(1);
    end
  end

`ifdef HIT_DETECTOR_MISS_EN
  logic r_miss;

  always_ff @(posedge clk) begin
    if (reset)
      r_miss <= 1'b0;
    else
      r_miss <= w_strike && (w_primed == '0);
  end

  assign miss_pulse = r_miss;
`else
  assign miss_pulse = 1'b0;
`endif

  assign hit_vec   = r_hit_vec;
  assign hit_pulse = |r_hit_vec;
  assign hit_count = r_hit_count;
  assign lockout   = w_lockout;

endmodule
